// File: rtl/phv_pkg.sv
// Shared PHV layout constants and the round-robin pick helper used by the
// queue collector. Sender and receiver both take the PHV geometry from here.
package phv_pkg;

   localparam int PHV_LEN_DEFAULT = 48*8 + 32*8 + 16*8 + 256;
   localparam int PHV_QUEUE_OFS   = 141;
   localparam int PHV_QUEUE_W     = 4;
   localparam int QID_W           = 2;
   localparam int NUM_QUEUES      = 4;

   typedef struct packed {
      logic             found;
      logic [QID_W-1:0] idx;
   } rr_pick_t;

   // First requesting lane in (rr+1)..(rr+NUM_QUEUES) order; the nearest
   // candidate is visited last so it overrides any farther one.
   function automatic rr_pick_t rr_pick(input logic [NUM_QUEUES-1:0] req,
                                        input logic [QID_W-1:0]      rr);
      rr_pick_t p;
      int       k;
      p = '0;
      for (int i = NUM_QUEUES; i >= 1; i--) begin
         k = (int'(rr) + i) % NUM_QUEUES;
         if (req[k]) begin
            p.found = 1'b1;
            p.idx   = QID_W'(k);
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/phv_lane_fifo.sv
// One lane of the collector: circular FIFO with almost-full ready, and a
// saturating counter of beats that arrived while the lane had no room.
module phv_lane_fifo
   import phv_pkg::*;
#(
   parameter int W     = PHV_LEN_DEFAULT,
   parameter int DEPTH = 16,
   parameter int SKID  = 3,
   parameter int CNT_W = 32
)(
   input  logic             axis_clk,
   input  logic             axis_rst,
   input  logic             wr_valid,
   input  logic [W-1:0]     wr_data,
   input  logic             rd_en,
   output logic [W-1:0]     rd_data,
   output logic             empty,
   output logic             ready,
   output logic [CNT_W-1:0] drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, count_nxt;
   logic          push, pop, ready_q;

   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];
   assign pop     = rd_en & ~empty;
   // Room is judged after this cycle's pop, so a full lane being read still
   // accepts a beat.
   assign push      = wr_valid && ((count - CW'(pop)) < CW'(DEPTH));
   assign count_nxt = count + CW'(push) - CW'(pop);
   assign ready     = ready_q & ~axis_rst;

   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         ready_q  <= 1'b1;
         drop_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count   <= count_nxt;
         ready_q <= count_nxt < CW'(DEPTH - SKID);
         if (wr_valid && !push && drop_cnt != '1)
            drop_cnt <= drop_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge axis_clk) begin
      if (push && !axis_rst) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/phv_queue_collector.sv
// Collects the four per-queue PHV lanes into per-lane FIFOs and merges them
// round-robin into one valid/ready stream tagged with the source queue.
module phv_queue_collector
   import phv_pkg::*;
#(
   parameter int PHV_LEN      = PHV_LEN_DEFAULT,
   parameter int C_NUM_QUEUES = 4,
   parameter int FIFO_DEPTH   = 16,
   parameter int SKID         = 3,
   parameter int CNT_W        = 32
)(
   input  logic               axis_clk,
   input  logic               axis_rst,
   input  logic [PHV_LEN-1:0] phv_in_0,
   input  logic [PHV_LEN-1:0] phv_in_1,
   input  logic [PHV_LEN-1:0] phv_in_2,
   input  logic [PHV_LEN-1:0] phv_in_3,
   input  logic               phv_in_valid_0,
   input  logic               phv_in_valid_1,
   input  logic               phv_in_valid_2,
   input  logic               phv_in_valid_3,
   output logic               phv_fifo_ready_0,
   output logic               phv_fifo_ready_1,
   output logic               phv_fifo_ready_2,
   output logic               phv_fifo_ready_3,
   output logic [PHV_LEN-1:0] m_phv,
   output logic [QID_W-1:0]   m_phv_queue,
   output logic               m_phv_valid,
   input  logic               m_phv_ready,
   output logic [CNT_W-1:0]   drop_cnt_0,
   output logic [CNT_W-1:0]   drop_cnt_1,
   output logic [CNT_W-1:0]   drop_cnt_2,
   output logic [CNT_W-1:0]   drop_cnt_3
);

   logic [C_NUM_QUEUES-1:0][PHV_LEN-1:0] lane_din, lane_head;
   logic [C_NUM_QUEUES-1:0][CNT_W-1:0]   lane_drop;
   logic [C_NUM_QUEUES-1:0]              lane_wr, lane_rd, lane_empty, lane_rdy;
   logic [QID_W-1:0]                     rr;
   logic                                 load;
   rr_pick_t                             pick;

   assign lane_din = {phv_in_3, phv_in_2, phv_in_1, phv_in_0};
   assign lane_wr  = {phv_in_valid_3, phv_in_valid_2, phv_in_valid_1, phv_in_valid_0};
   assign {phv_fifo_ready_3, phv_fifo_ready_2, phv_fifo_ready_1, phv_fifo_ready_0} = lane_rdy;
   assign drop_cnt_0 = lane_drop[0];
   assign drop_cnt_1 = lane_drop[1];
   assign drop_cnt_2 = lane_drop[2];
   assign drop_cnt_3 = lane_drop[3];

   for (genvar g = 0; g < C_NUM_QUEUES; g++) begin : g_lane
      phv_lane_fifo #(
         .W     (PHV_LEN),
         .DEPTH (FIFO_DEPTH),
         .SKID  (SKID),
         .CNT_W (CNT_W)
      ) u_lane (
         .axis_clk (axis_clk),
         .axis_rst (axis_rst),
         .wr_valid (lane_wr[g]),
         .wr_data  (lane_din[g]),
         .rd_en    (lane_rd[g]),
         .rd_data  (lane_head[g]),
         .empty    (lane_empty[g]),
         .ready    (lane_rdy[g]),
         .drop_cnt (lane_drop[g])
      );
   end

   // The holding register refills whenever it is empty or being drained.
   assign load = ~m_phv_valid | m_phv_ready;
   assign pick = rr_pick(~lane_empty, rr);

   always_comb begin
      lane_rd = '0;
      if (load && pick.found) lane_rd[pick.idx] = 1'b1;
   end

   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         m_phv       <= '0;
         m_phv_queue <= '0;
         m_phv_valid <= 1'b0;
         rr          <= '0;
      end else if (load) begin
         if (pick.found) begin
            m_phv       <= lane_head[pick.idx];
            m_phv_queue <= pick.idx;
            m_phv_valid <= 1'b1;
            rr          <= pick.idx;
         end else begin
            m_phv_valid <= 1'b0;
         end
      end
   end

endmodule
